// File: rtl/input_debounce_irq.sv
// Board button/switch conditioner: per-bit 2-FF synchroniser plus restart-on-bounce
// debounce, with one-cycle press/release pulses for each key.
module input_debounce_irq #(
    parameter int N_KEY           = 3,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_KEY-1:0] key_raw_i,
    input  logic [N_SW-1:0]  sw_raw_i,
    output logic [N_KEY-1:0] key_o,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_KEY-1:0] key_press_o,
    output logic [N_KEY-1:0] key_release_o
);

    localparam int N  = N_KEY + N_SW;
    // A one-cycle debounce would give a zero-width counter; keep at least one bit.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_KEY-1:0] KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_KEY-1:0] key_s1, key_s2;
    logic [N_SW-1:0]  sw_s1, sw_s2;
    logic [N-1:0]     norm;
    logic [N-1:0]     st;
    logic [N-1:0]     accept;
    logic [CW-1:0]    cnt [N];

    // Keys become active-high here; everything downstream assumes 1 = pressed.
    assign norm = {sw_s2, (KEY_ACTIVE_LOW != 0) ? ~key_s2 : key_s2};

    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = (norm[i] != st[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            key_s1        <= KEY_IDLE;
            key_s2        <= KEY_IDLE;
            sw_s1         <= '0;
            sw_s2         <= '0;
            st            <= '0;
            key_press_o   <= '0;
            key_release_o <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_s1 <= key_raw_i;
            key_s2 <= key_s1;
            sw_s1  <= sw_raw_i;
            sw_s2  <= sw_s1;
            for (int i = 0; i < N; i++) begin
                if (norm[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    st[i]  <= norm[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            // Pulses share the edge on which the stable level flips.
            key_press_o   <= accept[N_KEY-1:0] & norm[N_KEY-1:0];
            key_release_o <= accept[N_KEY-1:0] & ~norm[N_KEY-1:0];
        end
    end

    assign key_o = st[N_KEY-1:0];
    assign sw_o  = st[N-1:N_KEY];

endmodule

// File: tb/tb_input_debounce_irq.sv
// Scoreboard bench for input_debounce_irq (DEBOUNCE_CYCLES = 4, active-low keys).
// Stimulus queues the expected output change and its edge number; a monitor matches every observed change.
module tb_input_debounce_irq;

    typedef struct {
        int         cyc;
        logic [2:0] key;
        logic [9:0] sw;
        logic [2:0] press;
        logic [2:0] rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_raw;
    logic [9:0] sw_raw;
    logic [2:0] key_o, key_press, key_release;
    logic [9:0] sw_o;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   e0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    ev_t  exp_q[$];
    logic [2:0] kst = '0;
    logic [9:0] sst = '0;

    input_debounce_irq #(
        .N_KEY(3), .N_SW(10), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .key_raw_i(key_raw),
        .sw_raw_i(sw_raw),
        .key_o(key_o),
        .sw_o(sw_o),
        .key_press_o(key_press),
        .key_release_o(key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Queue the new debounced levels expected at edge c, plus the pulse drop one edge later.
    task automatic expect_levels(input int c, input logic [2:0] k, input logic [9:0] s);
        ev_t e;
        e.cyc = c; e.key = k; e.sw = s;
        e.press = k & ~kst;
        e.rel   = kst & ~k;
        exp_q.push_back(e);
        if ((e.press | e.rel) != 3'b000) begin
            e.cyc = c + 1; e.press = '0; e.rel = '0;
            exp_q.push_back(e);
        end
        kst = k;
        sst = s;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: new raw levels are first sampled at the next edge, e0.
    task automatic drive(input logic [2:0] k, input logic [9:0] s);
        key_raw = k;
        sw_raw  = s;
        e0      = cyc + 1;
    endtask

    initial begin : monitor
        logic [25:0] vec, prev;
        bit first;
        ev_t e;
        first = 1'b1;
        prev  = '0;
        wait (mon_en);
        while (!done) begin
            @(negedge clk);
            vec = {key_o, sw_o, key_press, key_release};
            if (first || vec !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d got key=%b sw=%h press=%b rel=%b, required no change",
                             cyc, key_o, sw_o, key_press, key_release);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || vec !== {e.key, e.sw, e.press, e.rel}) begin
                        fails++;
                        $display("FAIL out_change got cyc=%0d key=%b sw=%h press=%b rel=%b, required cyc=%0d key=%b sw=%h press=%b rel=%b",
                                 cyc, key_o, sw_o, key_press, key_release,
                                 e.cyc, e.key, e.sw, e.press, e.rel);
                    end
                end
            end
            first = 1'b0;
            prev  = vec;
        end
    end

    initial begin : stimulus
        int k1;
        rst_n   = 1'b0;
        key_raw = 3'b111;
        sw_raw  = '0;
        // Reset state must be all zero when first sampled after edge 1.
        begin
            ev_t z;
            z.cyc = 1; z.key = '0; z.sw = '0; z.press = '0; z.rel = '0;
            exp_q.push_back(z);
        end
        @(posedge clk);
        mon_en = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(20);

        // Clean press of key0.
        drive(3'b110, 10'h000);
        expect_levels(e0 + 5, 3'b001, sst);
        cycles(12);

        // Key1 bounce: low 3, high 1, four times, then held low.
        for (int r = 0; r < 4; r++) begin
            drive(3'b100, 10'h000); cycles(3);
            drive(3'b110, 10'h000); cycles(1);
        end
        drive(3'b100, 10'h000);
        expect_levels(e0 + 5, 3'b011, sst);
        cycles(12);

        // Switches, then a 2-cycle glitch on bit 3 that must be ignored.
        drive(3'b100, 10'h2A5);
        expect_levels(e0 + 5, kst, 10'h2A5);
        cycles(12);
        drive(3'b100, 10'h2AD); cycles(2);
        drive(3'b100, 10'h2A5); cycles(12);

        // Release keys 0,1 and press key2 on the same edge.
        drive(3'b011, 10'h2A5);
        expect_levels(e0 + 5, 3'b100, sst);
        cycles(12);

        // Press key0 and release key2 on the same edge.
        drive(3'b110, 10'h2A5);
        expect_levels(e0 + 5, 3'b001, sst);
        cycles(12);

        // Release key0 so the reset scenario starts from idle.
        drive(3'b111, 10'h000);
        expect_levels(e0 + 5, 3'b000, 10'h000);
        cycles(12);

        // Press key0, reset after two mismatch counts, release reset with key still low.
        drive(3'b110, 10'h000);
        cycles(4);
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        k1 = cyc + 1;
        expect_levels(k1 + 5, 3'b001, sst);
        cycles(14);

        done = 1'b1;
        cycles(2);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_change got none, required cyc=%0d key=%b sw=%h press=%b rel=%b",
                     e.cyc, e.key, e.sw, e.press, e.rel);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
